// File: rtl/bit_ram_pkg.sv
// Shared definitions for the 1-bit-wide, 16384-deep bit RAM and its word writer.
// The request struct is the FIFO payload between the accept port and the serializer.
package bit_ram_pkg;

  localparam int unsigned RAM_ADDR_W   = 14;
  localparam int unsigned RAM_DEPTH    = 16384;
  localparam int unsigned RAM_WINDOW_W = 17;
  localparam int unsigned REQ_LEN_W    = $clog2(RAM_WINDOW_W + 1);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_e;

  typedef struct packed {
    logic [RAM_ADDR_W-1:0]   addr;
    logic [RAM_WINDOW_W-1:0] data;
    logic [REQ_LEN_W-1:0]    len;
  } req_t;

  // Longer requests are truncated to one RAM window.
  function automatic logic [REQ_LEN_W-1:0] clamp_len(input logic [REQ_LEN_W-1:0] len);
    return (len > REQ_LEN_W'(RAM_WINDOW_W)) ? REQ_LEN_W'(RAM_WINDOW_W) : len;
  endfunction

endpackage

// File: rtl/bit_ram_word_writer_if.sv
// Request handshake plus the single RAM write port driven by the word writer.
// master = upstream requester, slave = the writer.
interface bit_ram_word_writer_if
  import bit_ram_pkg::*;
#(
  parameter int unsigned WORD_W = RAM_WINDOW_W,
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned LEN_W  = $clog2(WORD_W + 1)
);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [WORD_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;

  logic              ram_store;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_datain;
  logic              word_done;
  logic              busy;

  modport master (
    output in_valid, in_addr, in_data, in_len,
    input  in_ready, ram_store, ram_address, ram_datain, word_done, busy
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_len,
    output in_ready, ram_store, ram_address, ram_datain, word_done, busy
  );

endinterface

// File: rtl/bit_ram_req_fifo.sv
// Small synchronous FIFO of pending write requests with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module bit_ram_req_fifo
  import bit_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             push,
  input  req_t             push_data,
  input  logic             pop,
  output req_t             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bit_ram_word_writer.sv
// Serializes buffered word-write requests onto one bit-RAM write port, MSB first,
// one bit per cycle into consecutive (wrapping) bit addresses.
module bit_ram_word_writer
  import bit_ram_pkg::*;
#(
  parameter int unsigned WORD_W     = RAM_WINDOW_W,
  parameter int unsigned ADDR_W     = $clog2(RAM_DEPTH),
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned LEN_W      = $clog2(WORD_W + 1)
) (
  input logic                  clk,
  input logic                  clear_n,
  bit_ram_word_writer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  req_t             push_req;
  req_t             head;
  logic             push_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;

  state_e            state;
  state_e            state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] aligned;
  logic [LEN_W-1:0]  head_len;
  logic [LEN_W-1:0]  rem;

  logic              in_ready_q;
  logic              busy_q;
  logic              ram_store_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_datain_q;
  logic              word_done_q;

  // Zero-length requests are consumed here and never reach the FIFO.
  assign push_c = bus.in_valid && in_ready_q && !fifo_full && (bus.in_len != '0);

  always_comb begin
    push_req      = '0;
    push_req.addr = RAM_ADDR_W'(bus.in_addr);
    push_req.data = RAM_WINDOW_W'(bus.in_data);
    push_req.len  = clamp_len(REQ_LEN_W'(bus.in_len));
  end

  bit_ram_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clear_n  (clear_n),
    .push     (push_c),
    .push_data(push_req),
    .pop      (pop_c),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Word left-aligned so its MSB sits at the top of the shift register.
  assign head_len = LEN_W'(head.len);
  assign aligned  = WORD_W'(head.data) << (LEN_W'(WORD_W) - head_len);
  assign cnt_nxt  = count + CNT_W'(push_c) - CNT_W'(pop_c);

  // Next state and pop: a new word is loaded while idle or right on the last bit.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (rem == '0) begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      rem           <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      ram_store_q   <= 1'b0;
      ram_address_q <= '0;
      ram_datain_q  <= 1'b0;
      word_done_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (cnt_nxt < CNT_W'(FIFO_DEPTH));
      busy_q     <= (state_nxt == ST_WRITE) || (cnt_nxt != '0);
      if (pop_c) begin
        ram_store_q   <= 1'b1;
        ram_address_q <= ADDR_W'(head.addr);
        ram_datain_q  <= aligned[WORD_W-1];
        shreg         <= aligned << 1;
        rem           <= head_len - LEN_W'(1);
        word_done_q   <= (head_len == LEN_W'(1));
      end else if ((state == ST_WRITE) && (rem != '0)) begin
        ram_store_q   <= 1'b1;
        ram_address_q <= ram_address_q + ADDR_W'(1);
        ram_datain_q  <= shreg[WORD_W-1];
        shreg         <= shreg << 1;
        rem           <= rem - LEN_W'(1);
        word_done_q   <= (rem == LEN_W'(1));
      end else begin
        ram_store_q <= 1'b0;
        word_done_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.ram_store   = ram_store_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_datain  = ram_datain_q;
  assign bus.word_done   = word_done_q;

endmodule

// File: doc/bit_ram_word_writer.md
# bit_ram_word_writer

Upstream write serializer for the multi-port 1-bit-wide, 16384-deep bit RAM. Accepts whole words (up to 17 bits: data, address or address+condition fields) with a base bit address over a valid/ready handshake. Buffers them in a small FIFO. Drives one RAM write port one bit per cycle, MSB first, into consecutive bit addresses, so that a later 17-bit window read at the base address returns the word MSB-aligned.

## Interface
Parameters:
- WORD_W, 17, maximum word length in bits (matches RAM window width)
- ADDR_W, 14, RAM bit-address width (depth 2^ADDR_W)
- FIFO_DEPTH, 2, pending-request buffer entries (≥1)
- LEN_W, $clog2(WORD_W+1), width of length field

Ports:
- clk  in  1  system clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted
- in_addr  in  ADDR_W  base bit address
- in_data  in  WORD_W  word; low in_len bits are written
- in_len  in  LEN_W  bits to write
- ram_store  out  1  RAM write strobe for this port
- ram_address  out  ADDR_W  RAM bit address
- ram_datain  out  1  bit to write
- word_done  out  1  pulse in the cycle carrying the last bit of a word
- busy  out  1  engine active or FIFO non-empty

## Operation
- Accept on the rising edge when in_valid && in_ready. in_ready = (FIFO count < FIFO_DEPTH). There is no combinational pass-through from a pop in the same cycle.
- Length rules, applied at accept:
  - in_len = 0: request consumed and discarded; nothing enqueued, no stores, no word_done.
  - in_len > WORD_W: clamped to WORD_W.
- Engine FSM:
  - IDLE → WRITE when the FIFO is non-empty. Pop loads the shift register, address counter and remaining-count.
  - WRITE: for bit k = 0..len-1, write in_data[len-1-k] to (in_addr + k) mod 2^ADDR_W.
  - On the last bit, if the FIFO is non-empty, pop the next entry and stay in WRITE (no bubble). Otherwise go to IDLE.
- Address arithmetic is ADDR_W-bit unsigned and wraps 16383 → 0.
- Outputs ram_store, ram_address, ram_datain and word_done are registered.
- ram_address and ram_datain hold their last values when ram_store = 0.
- Simultaneous accept and pop in one cycle is legal; the count is unchanged.

## Timing
- Accept sampled at the end of cycle 0. FIFO visible in cycle 1. Engine loads at the end of cycle 1. ram_store = 1 in cycles 2 .. len+1.
- Latency from accept to first store: 2 cycles. Throughput: 1 bit/cycle sustained across back-to-back words.
- word_done = 1 exactly in cycle len+1 (coincident with the last ram_store).
- Reset (clear_n low, asynchronous), all outputs:
  - ram_store = 0, ram_address = 0, ram_datain = 0, word_done = 0, busy = 0, in_ready = 0.
  - FIFO emptied; FSM to IDLE.
  - in_ready rises in the first cycle after clear_n deasserts.
- Reset mid-word: the word is abandoned immediately. Bits already written stay in the RAM; no further stores occur.

## Structure
- Shared package bit_ram_pkg holds:
  - RAM_ADDR_W = 14, RAM_DEPTH = 16384, RAM_WINDOW_W = 17
  - state enum {ST_IDLE, ST_WRITE}
  - request struct {addr, data, len}
- One sub-module: bit_ram_req_fifo, a synchronous FIFO of request structs with count, full and empty, reset by clear_n.
- The top level holds the FSM, shift register, address counter and output registers.

## Test plan
- Full word: addr 100, data 17'h1A5C3, len 17. Required: stores in cycles 2–18 to addresses 100–116, bits 1,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. word_done in cycle 18.
- Wrap: addr 16380, data 8'hA5, len 8. Required: addresses 16380,16381,16382,16383,0,1,2,3 with bits 1,0,1,0,0,1,0,1.
- Back-to-back: three len-4 requests offered every cycle. Required:
  - in_ready drops when the FIFO holds 2 entries.
  - 12 consecutive store cycles with no gap.
  - word_done on the 4th, 8th and 12th store.
- Length edges:
  - len 0: accepted, no stores, no word_done, busy stays 0.
  - len 20: exactly 17 stores, using in_data[16:0].
- Reset mid-word: clear_n low during the 5th bit of a len-17 write. Required:
  - ram_store = 0 immediately; FIFO empty; no further stores after release.
  - A new request issued after release writes normally with 2-cycle latency.
